// File: rtl/fastica_pkg.sv
// Shared definitions for the FastICA iteration datapath.
//   W        element width (signed fixed point)
//   MAT_N    number of elements in the 4x4 unmixing matrix
//   SAT_MAX  largest positive W-bit value, used as the distance ceiling
//   state_t  control states of the weight delta calculator
//   elem_idx flat packing index of elem(r,c), r,c = 1..4
package fastica_pkg;

  localparam int W     = 26;
  localparam int MAT_N = 16;
  localparam logic [W-1:0] SAT_MAX = W'((64'sd1 <<< (W - 1)) - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int elem_idx(input int r, input int c);
    return 4 * (r - 1) + (c - 1);
  endfunction

endpackage

// File: rtl/abs_dist_sat.sv
// Combinational distance between two signed W-bit elements.
//   i_a        new element (signed)
//   i_b        previous element (signed)
//   i_sign_inv 1: d = min(|a-b|, |a+b|); 0: d = |a-b|
//   o_d        distance, saturated to 2^(W-1)-1, never negative
module abs_dist_sat #(
  parameter int W = 26
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sign_inv,
  output logic [W-1:0] o_d
);

  localparam logic [W:0] L_SAT = {2'b00, {(W - 1){1'b1}}};

  logic [W:0] w_a;
  logic [W:0] w_b;
  logic [W:0] w_diff;
  logic [W:0] w_sum;
  logic [W:0] w_mag_diff;
  logic [W:0] w_mag_sum;
  logic [W:0] w_mag;

  // One extra bit keeps a-b and a+b exact; the magnitudes are read as
  // unsigned so |-(2^W)| = 2^W is still representable before saturation.
  assign w_a        = {i_a[W-1], i_a};
  assign w_b        = {i_b[W-1], i_b};
  assign w_diff     = w_a - w_b;
  assign w_sum      = w_a + w_b;
  assign w_mag_diff = w_diff[W] ? (~w_diff + 1'b1) : w_diff;
  assign w_mag_sum  = w_sum[W] ? (~w_sum + 1'b1) : w_sum;
  assign w_mag      = (i_sign_inv && (w_mag_sum < w_mag_diff)) ? w_mag_sum : w_mag_diff;
  assign o_d        = (w_mag > L_SAT) ? L_SAT[W-1:0] : w_mag[W-1:0];

endmodule

// File: rtl/weight_delta_calc.sv
// Compares a new 4x4 unmixing matrix against the previously accepted one and
// produces an element-wise distance matrix plus a snapshot of the new matrix.
//   clk, rstn   clock (rising edge), asynchronous active-low reset
//   start       request a compare; accepted only in IDLE
//   clear       empties the history; aborts a running compare; beats start
//   w_new_flat  new matrix, elem(r,c) at [W*(4*(r-1)+(c-1)) +: W]
//   busy        high while elements are being computed
//   done        one-cycle pulse; w_out_flat and d_flat are valid
//   first       valid with done; 1 = no history existed, all d saturated
//   w_out_flat  snapshot of w_new_flat taken when start was accepted
//   d_flat      distance matrix, same packing, every element >= 0
//   dbg_state   current control state
//
// Handshake: start is a level sampled on the rising edge; it is consumed only
// when the block is IDLE and clear is low, otherwise it is dropped with no
// queueing. done is a single-cycle strobe; its data holds until the next
// accepted start.
module weight_delta_calc
  import fastica_pkg::*;
#(
  parameter int W        = fastica_pkg::W,
  parameter int LANES    = 1,
  parameter int SIGN_INV = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               clear,
  input  logic [MAT_N*W-1:0] w_new_flat,
  output logic               busy,
  output logic               done,
  output logic               first,
  output logic [MAT_N*W-1:0] w_out_flat,
  output logic [MAT_N*W-1:0] d_flat,
  output logic [1:0]         dbg_state
);

  localparam int              KW     = $clog2(MAT_N);
  localparam logic [KW-1:0]   K_LAST = KW'(MAT_N - LANES);
  localparam logic [KW-1:0]   K_STEP = KW'(LANES);
  localparam logic [W-1:0]    L_SAT  = {1'b0, {(W - 1){1'b1}}};

  state_t               r_state;
  logic [KW-1:0]        r_k;
  logic [MAT_N*W-1:0]   r_snap;
  logic [MAT_N*W-1:0]   r_hist;
  logic                 r_hist_valid;
  logic [MAT_N*W-1:0]   r_d;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_first;

  logic [W-1:0]         w_lane_d [LANES];

  // Each lane handles element r_k + l of the current group.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [KW-1:0] w_idx;
    assign w_idx = r_k + KW'(l);
    abs_dist_sat #(.W(W)) u_dist (
      .i_a        (r_snap[W*w_idx +: W]),
      .i_b        (r_hist[W*w_idx +: W]),
      .i_sign_inv (1'(SIGN_INV)),
      .o_d        (w_lane_d[l])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_k          <= '0;
      r_snap       <= '0;
      r_hist       <= '0;
      r_hist_valid <= 1'b0;
      r_d          <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_first      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (clear) begin
            r_hist       <= '0;
            r_hist_valid <= 1'b0;
          end else if (start) begin
            r_snap  <= w_new_flat;
            r_k     <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (clear) begin
            // Abort keeps the stored matrix but marks it unusable.
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_k          <= '0;
            r_hist_valid <= 1'b0;
          end else begin
            for (int l = 0; l < LANES; l++) begin
              r_d[W*(int'(r_k) + l) +: W] <= r_hist_valid ? w_lane_d[l] : L_SAT;
            end
            r_k <= r_k + K_STEP;
            if (r_k == K_LAST) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_first <= ~r_hist_valid;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
          if (clear) begin
            r_hist       <= '0;
            r_hist_valid <= 1'b0;
          end else begin
            r_hist       <= r_snap;
            r_hist_valid <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign first      = r_first;
  assign w_out_flat = r_snap;
  assign d_flat     = r_d;
  assign dbg_state  = r_state;

endmodule
